// File: rtl/key_pkg.sv
// Shared definitions for the key input front end: debounce state encoding,
// stepper key indices and a small sizing helper.
package key_pkg;

  typedef enum logic [1:0] {
    S_LO     = 2'd0,
    S_CHK_HI = 2'd1,
    S_HI     = 2'd2,
    S_CHK_LO = 2'd3
  } db_state_t;

  localparam int unsigned KEY_UP   = 0;
  localparam int unsigned KEY_DOWN = 1;

  function automatic int unsigned umax(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/key_debounce.sv
// Single-key conditioner: 2-flop synchronizer, four-state debounce FSM and
// one-cycle press / release pulses on accepted level changes.
module key_debounce
  import key_pkg::*;
#(
  parameter int unsigned DB_CYCLES = 1_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic key_raw,
  output logic level,
  output logic press,
  output logic rel
);

  localparam int unsigned DB_EFF = (DB_CYCLES < 1) ? 1 : DB_CYCLES;
  localparam int unsigned CW     = $clog2(DB_EFF + 1);
  localparam logic [CW-1:0] DB_END = CW'(DB_EFF);
  localparam bit DB_ONE = (DB_EFF == 1);

  logic [1:0]    sync_q;
  logic          key_s;
  db_state_t     state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          press_q, press_d;
  logic          rel_q, rel_d;

  assign key_s = sync_q[1];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_q  <= '0;
      state_q <= S_LO;
      cnt_q   <= '0;
      press_q <= 1'b0;
      rel_q   <= 1'b0;
    end else begin
      sync_q  <= {sync_q[0], key_raw};
      state_q <= state_d;
      cnt_q   <= cnt_d;
      press_q <= press_d;
      rel_q   <= rel_d;
    end
  end

  // cnt holds the number of consecutive samples seen at the candidate level;
  // it never exceeds DB_END, so the increment cannot wrap.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    press_d = 1'b0;
    rel_d   = 1'b0;
    unique case (state_q)
      S_LO: begin
        if (key_s) begin
          if (DB_ONE) begin
            state_d = S_HI;
            cnt_d   = '0;
            press_d = 1'b1;
          end else begin
            state_d = S_CHK_HI;
            cnt_d   = CW'(1);
          end
        end
      end
      S_CHK_HI: begin
        if (!key_s) begin
          state_d = S_LO;
          cnt_d   = '0;
        end else if (cnt_q >= DB_END - CW'(1)) begin
          state_d = S_HI;
          cnt_d   = '0;
          press_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_HI: begin
        if (!key_s) begin
          if (DB_ONE) begin
            state_d = S_LO;
            cnt_d   = '0;
            rel_d   = 1'b1;
          end else begin
            state_d = S_CHK_LO;
            cnt_d   = CW'(1);
          end
        end
      end
      S_CHK_LO: begin
        if (key_s) begin
          state_d = S_HI;
          cnt_d   = '0;
        end else if (cnt_q >= DB_END - CW'(1)) begin
          state_d = S_LO;
          cnt_d   = '0;
          rel_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
    endcase
  end

  assign level = (state_q == S_HI) || (state_q == S_CHK_LO);
  assign press = press_q;
  assign rel   = rel_q;

endmodule

// File: rtl/key_input_ctrl.sv
// Push-button front end: per-key debounce plus the memory-browse address
// stepper with wrap detection and hold-to-auto-repeat.
module key_input_ctrl
  import key_pkg::*;
#(
  parameter int unsigned NKEYS        = 4,
  parameter int unsigned DB_CYCLES    = 1_000_000,
  parameter int unsigned REPEAT_DELAY = 50_000_000,
  parameter int unsigned REPEAT_RATE  = 10_000_000,
  parameter int unsigned ADDR_W       = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NKEYS-1:0]  key_raw,
  input  logic              browse_en,
  output logic [NKEYS-1:0]  key_level,
  output logic [NKEYS-1:0]  key_press,
  output logic [NKEYS-1:0]  key_release,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              addr_wrap
);

  localparam int unsigned RMAX = umax(umax(DB_CYCLES, REPEAT_DELAY), REPEAT_RATE);
  localparam int unsigned RW   = $clog2(RMAX + 1);
  localparam logic [RW-1:0] RD_END = RW'(REPEAT_DELAY);
  localparam logic [RW-1:0] RR_END = RW'(REPEAT_RATE);
  localparam logic [RW-1:0] R_SAT  = RW'(RMAX);

  for (genvar g = 0; g < NKEYS; g++) begin : g_key
    key_debounce #(
      .DB_CYCLES (DB_CYCLES)
    ) u_db (
      .clk     (clk),
      .rst     (rst),
      .key_raw (key_raw[g]),
      .level   (key_level[g]),
      .press   (key_press[g]),
      .rel     (key_release[g])
    );
  end

  logic              up_lv, dn_lv, up_pr, dn_pr;
  logic [RW-1:0]     rcnt_q, rcnt_d;
  logic              armed_q, armed_d;
  logic              step_up, step_dn;
  logic [ADDR_W-1:0] addr_d;
  logic              wrap_d;

  assign up_lv = key_level[KEY_UP];
  assign dn_lv = key_level[KEY_DOWN];
  assign up_pr = key_press[KEY_UP];
  assign dn_pr = key_press[KEY_DOWN];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mem_addr  <= '0;
      addr_wrap <= 1'b0;
      rcnt_q    <= '0;
      armed_q   <= 1'b0;
    end else begin
      mem_addr  <= addr_d;
      addr_wrap <= wrap_d;
      rcnt_q    <= rcnt_d;
      armed_q   <= armed_d;
    end
  end

  // rcnt = cycles since the last step of the held key (0 = idle); armed
  // switches the target from the initial delay to the repeat rate.
  always_comb begin
    addr_d  = mem_addr;
    wrap_d  = 1'b0;
    rcnt_d  = rcnt_q;
    armed_d = armed_q;
    step_up = 1'b0;
    step_dn = 1'b0;
    if (!browse_en) begin
      addr_d  = '0;
      rcnt_d  = '0;
      armed_d = 1'b0;
    end else if (up_lv && dn_lv) begin
      rcnt_d  = '0;
      armed_d = 1'b0;
    end else if (up_pr || dn_pr) begin
      step_up = up_pr;
      step_dn = dn_pr;
      rcnt_d  = RW'(1);
      armed_d = 1'b0;
    end else if ((up_lv || dn_lv) && (rcnt_q != '0)) begin
      if (rcnt_q == (armed_q ? RR_END : RD_END)) begin
        step_up = up_lv;
        step_dn = dn_lv;
        rcnt_d  = RW'(1);
        armed_d = 1'b1;
      end else if (rcnt_q != R_SAT) begin
        rcnt_d = rcnt_q + RW'(1);
      end
    end else begin
      rcnt_d  = '0;
      armed_d = 1'b0;
    end

    if (step_up) begin
      addr_d = mem_addr + ADDR_W'(1);
      wrap_d = &mem_addr;
    end else if (step_dn) begin
      addr_d = mem_addr - ADDR_W'(1);
      wrap_d = ~|mem_addr;
    end
  end

endmodule

// File: doc/key_input_ctrl.md
Name: key_input_ctrl

Overview:
Input-side front end for the board wrapper; it is the input counterpart of the 7-segment display path. It conditions raw push-buttons (2-flop sync, per-key debounce FSM, edge pulses). It also owns the memory-browse address stepper (up/down with wrap and hold-to-auto-repeat). This replaces ad-hoc key_lock logic in the top level; mem_addr feeds the CPU memAddr debug port.

Parameters:
NKEYS, 4, number of raw keys; bit 0 = addr up, bit 1 = addr down, rest general purpose
DB_CYCLES, 1_000_000, consecutive stable clk samples required to accept a new key level (10 ms @ 100 MHz)
REPEAT_DELAY, 50_000_000, hold cycles after press before the first auto-repeat step
REPEAT_RATE, 10_000_000, cycles between subsequent auto-repeat steps
ADDR_W, 10, width of mem_addr

Ports:
clk  in  1  system clock
rst  in  1  reset; asynchronous, active-low
key_raw  in  NKEYS  raw, asynchronous, bouncing button inputs, active-high
browse_en  in  1  memory-browse mode enable (driven from dataSel[2])
key_level  out  NKEYS  debounced key levels
key_press  out  NKEYS  one-cycle pulse on debounced rising edge
key_release  out  NKEYS  one-cycle pulse on debounced falling edge
mem_addr  out  ADDR_W  browse address
addr_wrap  out  1  one-cycle pulse when a step wraps (max->0 or 0->max)

Behaviour:
- Reset (rst=0, async): all outputs 0; every debounce FSM in S_LO with counter 0; sync flops 0; repeat counter 0.
- Sync: 2 flops per key; FSM sees key_s (2-cycle latency).
- Debounce FSM per key: S_LO, S_CHK_HI, S_HI, S_CHK_LO.
  - S_LO & key_s=1 -> S_CHK_HI, cnt=1.
  - S_CHK_HI & key_s=1: cnt+1; when cnt reaches DB_CYCLES -> S_HI, key_level=1, key_press pulse.
  - S_CHK_HI & key_s=0 -> S_LO, cnt=0 (bounce rejected, no pulse).
  - S_HI / S_CHK_LO: mirror image, producing key_release.
- Latency: a clean raw edge held steady gives key_level/pulse exactly 2+DB_CYCLES clk after the raw edge. Glitches shorter than DB_CYCLES never produce a pulse.
- A key held through reset release yields a key_press after debounce.
- Stepper is active only when browse_en=1:
  - key_press[0] alone: mem_addr+1 mod 2^ADDR_W.
  - key_press[1] alone: mem_addr-1 mod 2^ADDR_W.
  - Applied the cycle after the pulse.
- Simultaneous up and down (both levels high): no step, and the repeat counter is held at 0.
- Auto-repeat: while exactly one of level[0]/level[1] is high, the repeat counter counts from the press. The first extra step occurs REPEAT_DELAY cycles after the press pulse, then one every REPEAT_RATE cycles. Release clears the counter.
- addr_wrap pulses in the same cycle mem_addr is updated across the boundary: 2^ADDR_W-1 -> 0 on up, 0 -> 2^ADDR_W-1 on down.
- browse_en=0: mem_addr cleared to 0 on the next clk, steps ignored, repeat counter cleared, addr_wrap=0. Debounce outputs keep running.
- browse_en rising while a key is held: no step until a fresh press.
- Counters are sized to hold max(DB_CYCLES, REPEAT_DELAY) and saturate; they never wrap.

Decomposition:
- Shared package key_pkg: debounce state encoding (S_LO=2'd0, S_CHK_HI=2'd1, S_HI=2'd2, S_CHK_LO=2'd3), KEY_UP=0, KEY_DOWN=1 index constants.
- Sub-module key_debounce: one key, containing sync + FSM + counter, with outputs level/press/release. It is instantiated NKEYS times via generate.
- Stepper and auto-repeat logic stay in key_input_ctrl.

Test Plan:
Test parameters for all scenarios: DB_CYCLES=4, REPEAT_DELAY=20, REPEAT_RATE=5, ADDR_W=4.
- Clean press: key_raw[2] 0->1 held 10 cycles -> key_level[2]=1 and key_press[2] one-cycle pulse exactly 6 cycles after the edge; release gives key_release[2] 6 cycles after the falling edge.
- Bounce: key_raw[2] toggles 1,0,1,0 each 2 cycles, then stays 0 -> no key_press, key_level stays 0.
- Stepping with wrap: browse_en=1, mem_addr=15, press up -> mem_addr=0 and addr_wrap pulses once; press down -> mem_addr=15 and addr_wrap pulses.
- Auto-repeat: browse_en=1, hold up 40 cycles after debounce from addr 0 -> steps at press, +20, +25, +30, +35 -> mem_addr=5.
- Simultaneous: up and down debounced in the same cycle -> mem_addr unchanged and no repeat after 40 cycles; browse_en dropped at mem_addr=7 -> mem_addr=0 next cycle.
- Async reset mid-debounce: rst=0 while in S_CHK_HI -> outputs 0 immediately without clk; key still held after rst=1 -> key_press 6 cycles later.
